pb_keyscan: RTL

PB_KEYSCAN -- requirements
Module: pb_keyscan

---
 rtl/pb_keyscan_if.sv | 25 ++
 rtl/pb_keyscan.sv | 118 +++++++++++
 2 files changed

// File: rtl/pb_keyscan_if.sv
// Key event bundle between the raw pushbutton bank, the scanner and the game FSM.
// The master drives the buttons and consumes the key event; the slave is the scanner.
interface pb_keyscan_if;
    logic [19:0] pb;
    logic [4:0]  keycode;
    logic        keyvalid;
    logic        held;
    logic        multi;

    modport master (
        output pb,
        input  keycode,
        input  keyvalid,
        input  held,
        input  multi
    );

    modport slave (
        input  pb,
        output keycode,
        output keyvalid,
        output held,
        output multi
    );
endinterface

// File: rtl/pb_keyscan.sv
// Pushbutton scanner: synchronises 20 raw buttons, debounces one tracked key at a
// time and emits one encoded strobe per press, plus held/multi status.
module pb_keyscan #(
    parameter logic [3:0] DB_CYCLES = 4'd3
) (
    input  logic         hz100,
    input  logic         reset,
    pb_keyscan_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        PRESSED,
        HOLD,
        RELEASE
    } state_t;

    logic [19:0] r_pb_p0;
    logic [19:0] r_pb_p1;
    logic [19:0] w_s;
    logic        w_cand_set;
    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [4:0]  r_cand;
    logic [4:0]  r_keycode;
    logic        r_keyvalid;
    logic        r_held;
    logic        r_multi;

    function automatic logic [4:0] lowest_idx(input logic [19:0] v);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = 19; i >= 0; i--) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

    // Clearing the lowest set bit leaves something only if two or more were set.
    function automatic logic more_than_one(input logic [19:0] v);
        return (v & (v - 20'd1)) != 20'd0;
    endfunction

    assign w_s        = r_pb_p1;
    assign w_cand_set = w_s[r_cand];

    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            r_pb_p0    <= '0;
            r_pb_p1    <= '0;
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_cand     <= 5'd0;
            r_keycode  <= 5'd0;
            r_keyvalid <= 1'b0;
            r_held     <= 1'b0;
            r_multi    <= 1'b0;
        end else begin
            // synchroniser stages p0 -> p1
            r_pb_p0    <= bus.pb;
            r_pb_p1    <= r_pb_p0;
            r_keyvalid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_s != 20'd0) begin
                        r_cand  <= lowest_idx(w_s);
                        r_cnt   <= 4'd1;
                        r_state <= DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (!w_cand_set) begin
                        r_state <= IDLE;
                    end else if (r_cnt == DB_CYCLES) begin
                        r_state    <= PRESSED;
                        r_keyvalid <= 1'b1;
                        r_keycode  <= r_cand;
                        r_multi    <= more_than_one(w_s);
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                PRESSED: begin
                    r_state <= HOLD;
                    r_held  <= 1'b1;
                end
                HOLD: begin
                    if (w_s == 20'd0) begin
                        r_cnt   <= 4'd1;
                        r_state <= RELEASE;
                    end
                end
                RELEASE: begin
                    // Any activity while releasing counts as a bounce of the held key.
                    if (w_s != 20'd0) begin
                        r_state <= HOLD;
                    end else if (r_cnt == DB_CYCLES) begin
                        r_state <= IDLE;
                        r_held  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_held  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.keycode  = r_keycode;
    assign bus.keyvalid = r_keyvalid;
    assign bus.held     = r_held;
    assign bus.multi    = r_multi;

endmodule
